avl_pio_multi: RTL and testbench
================================

Name: avl_pio_multi

Overview:
- Parametrised successor to the single-purpose Qsys PIO slaves (pio_led, pio_sw, pio_hex_*).
- One Avalon-MM slave provides NCH independent channels, each WIDTH bits wide.
- Each channel has an output register with atomic set/clear, a synchronised input port, edge capture and a maskable interrupt.
- Reads use pipelined readdatavalid and a response code; the block sits on the dmem interconnect beside the UART bridge.

Parameters:
- NCH, 4, number of channels (1..16); localparam ADDR_W = clog2(NCH)+3 word-address bits.
- WIDTH, 16, bits per channel (1..32).
- EDGE_MODE, 0, edge-capture polarity: 0 rising, 1 falling, 2 both.
- RD_LAT, 1, read latency in cycles from accepted read to readdatavalid (1 or 2).
- OUT_RST, 0, reset value of every output register (WIDTH bits).

Ports:
- clk_clk  in  1  system clock, all logic rising-edge.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  word address: [ADDR_W-1:3] channel, [2:0] register.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data (bits above WIDTH ignored).
- avs_byteenable  in  4  byte lanes for writes.
- avs_waitrequest  out  1  constant 0 (no stall).
- avs_readdata  out  32  read data (zero-extended above WIDTH).
- avs_readdatavalid  out  1  one-cycle pulse, RD_LAT after read accept.
- avs_response  out  2  00 OKAY, 10 SLAVEERROR; valid with readdatavalid.
- pio_in  in  NCH*WIDTH  asynchronous inputs; channel c at [c*WIDTH +: WIDTH].
- pio_out  out  NCH*WIDTH  registered outputs, same packing.
- irq  out  1  level interrupt.

Behaviour:
- Reset values: pio_out = OUT_RST per channel; EDGE = 0; IRQMASK = 0; synchronisers = 0; readdatavalid = 0; readdata = 0; response = 00; irq = 0; arm counter = 0.
- Register map per channel (reg field):
  - 0 IN: RO, synchronised input.
  - 1 OUT: RW, output register.
  - 2 SET: WO, OUT |= wdata; reads return OUT.
  - 3 CLR: WO, OUT &= ~wdata; reads return OUT.
  - 4 EDGE: RW1C capture.
  - 5 IRQMASK: RW.
  - 6, 7 reserved.
- Write masking: writes honour byteenable per byte lane; lanes at or above WIDTH are don't-care. SET/CLR/W1C apply only to enabled lanes.
- Input path: 2-flop synchroniser, then a delay flop; edge = function of (sync, prev) per EDGE_MODE. IN reads the sync stage (latency 2 from pin).
- Arm counter: a 2-bit counter saturates at 3 after reset. Edge detection is disabled until it saturates, so inputs held high through reset never raise spurious edges.
- EDGE update: EDGE[c] <= (EDGE[c] & ~w1c_mask) | detected. A new edge in the same cycle as a W1C of that bit leaves the bit set.
- irq: registered OR over all channels of |(EDGE[c] & IRQMASK[c]); updates 1 cycle after EDGE/IRQMASK change.
- Read pipeline:
  - Read accepted when avs_read=1 (waitrequest is always 0).
  - Data and response are sampled at accept and shifted through an RD_LAT-deep valid/data pipe.
  - Back-to-back reads every cycle are supported, one result per cycle, in order.
- Errors: channel field >= NCH, or reg 6/7 → write ignored; a read returns readdata=0 with response=10. All other accesses return 00.
- avs_read and avs_write together: the write is performed and the read is dropped (no readdatavalid).
- Reset asserted mid-read: the pipe is flushed and no readdatavalid is issued for outstanding reads.
- Outputs change the cycle after a write is accepted (one-cycle write latency).

Test Plan:
- Reset with OUT_RST=16'hA5A5, NCH=4 → all pio_out = A5A5, irq=0; read ch2 OUT → readdatavalid exactly 1 cycle later (RD_LAT=1), data 0000A5A5, response 00.
- Write ch1 OUT=16'h00F0, SET=16'h0F00, then CLR=16'h0030 → pio_out[31:16] = 00F0, then 0FF0, then 0FC0; write OUT with byteenable=4'b0001, wdata=0x1234 → low byte only, giving 0F34.
- EDGE_MODE=0: hold pio_in ch0 bit3 high through reset and release → EDGE stays 0. Then 0→1 pulse → EDGE[0]=0x0008; with IRQMASK[0]=0x0008, irq=1 one cycle later. W1C 0x0008 → EDGE=0, irq drops the next cycle.
- Rising edge on ch3 bit0 in the same cycle as W1C of bit0 → EDGE[3] bit0 remains 1, irq stays asserted.
- Read ch address 5 with NCH=4, and read reg 7 of ch0 → readdata 0, response 10; a write to the same address leaves all state unchanged.
- RD_LAT=2, reads on 4 consecutive cycles to IN/OUT/EDGE/IRQMASK → 4 consecutive readdatavalid pulses, starting 2 cycles after the first read, data in order. Reset asserted after 2nd read accept → no further readdatavalid.

Source files
------------

// File: rtl/avl_pio_multi.sv
// Multi-channel Avalon-MM PIO: per-channel output register with atomic set/clear,
// synchronised inputs, edge capture, maskable level interrupt and pipelined reads.
module avl_pio_multi #(
    parameter int NCH = 4,
    parameter int WIDTH = 16,
    parameter int EDGE_MODE = 0,
    parameter int RD_LAT = 1,
    parameter logic [WIDTH-1:0] OUT_RST = '0,
    localparam int ADDR_W = $clog2(NCH) + 3
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic [3:0]              avs_byteenable,
    output logic                    avs_waitrequest,
    output logic [31:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic [1:0]              avs_response,
    input  logic [NCH*WIDTH-1:0]    pio_in,
    output logic [NCH*WIDTH-1:0]    pio_out,
    output logic                    irq
);
    localparam int CH_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;
    localparam logic [2:0] R_IN = 3'd0, R_OUT = 3'd1, R_SET = 3'd2, R_CLR = 3'd3,
                           R_EDGE = 3'd4, R_MASK = 3'd5;

    logic [WIDTH-1:0] out_q [NCH], out_d [NCH];
    logic [WIDTH-1:0] edge_q [NCH], edge_d [NCH];
    logic [WIDTH-1:0] mask_q [NCH], mask_d [NCH];
    logic [WIDTH-1:0] w1c_m [NCH];
    logic [NCH*WIDTH-1:0] sync1_q, sync2_q, prev_q, det;
    logic [1:0] arm_q, arm_d;
    logic irq_q, irq_d;
    logic        rv_q   [RD_LAT];
    logic [31:0] rdat_q [RD_LAT];
    logic [1:0]  rrsp_q [RD_LAT];

    logic [ADDR_W-1:0] addr_shift;
    logic [CH_W-1:0]   ch_idx;
    logic [2:0]        reg_idx;
    logic              addr_ok, rd_acc;
    logic [NCH-1:0]    wr_sel;
    logic [WIDTH-1:0]  be_mask, wdata, wd_m;
    logic [31:0]       rd_data;
    logic [1:0]        rd_rsp;

    always_comb begin
        addr_shift = avs_address >> 3;
        ch_idx     = addr_shift[CH_W-1:0];
        reg_idx    = avs_address[2:0];
        addr_ok    = (32'(ch_idx) < NCH) && (reg_idx <= R_MASK);
        wdata      = avs_writedata[WIDTH-1:0];
        for (int i = 0; i < WIDTH; i++) be_mask[i] = avs_byteenable[i/8];
        wd_m       = wdata & be_mask;
        rd_acc     = avs_read & ~avs_write;
        arm_d      = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    // Edges are suppressed until the arm counter saturates so pins held through reset stay quiet.
    always_comb begin
        det = '0;
        if (arm_q == 2'd3) begin
            case (EDGE_MODE)
                0:       det = sync2_q & ~prev_q;
                1:       det = ~sync2_q & prev_q;
                default: det = sync2_q ^ prev_q;
            endcase
        end
    end

    always_comb begin
        irq_d = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            wr_sel[c] = avs_write && addr_ok && (ch_idx == CH_W'(c));
            out_d[c]  = out_q[c];
            mask_d[c] = mask_q[c];
            w1c_m[c]  = '0;
            if (wr_sel[c]) begin
                case (reg_idx)
                    R_OUT:   out_d[c]  = (out_q[c] & ~be_mask) | wd_m;
                    R_SET:   out_d[c]  = out_q[c] | wd_m;
                    R_CLR:   out_d[c]  = out_q[c] & ~wd_m;
                    R_EDGE:  w1c_m[c]  = wd_m;
                    R_MASK:  mask_d[c] = (mask_q[c] & ~be_mask) | wd_m;
                    default: ;
                endcase
            end
            edge_d[c] = (edge_q[c] & ~w1c_m[c]) | det[c*WIDTH +: WIDTH];
            irq_d     = irq_d | (|(edge_q[c] & mask_q[c]));
        end
    end

    always_comb begin
        rd_data = '0;
        rd_rsp  = addr_ok ? 2'b00 : 2'b10;
        if (addr_ok) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_idx == CH_W'(c)) begin
                    case (reg_idx)
                        R_IN:                rd_data = 32'(sync2_q[c*WIDTH +: WIDTH]);
                        R_OUT, R_SET, R_CLR: rd_data = 32'(out_q[c]);
                        R_EDGE:              rd_data = 32'(edge_q[c]);
                        R_MASK:              rd_data = 32'(mask_q[c]);
                        default:             rd_data = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int c = 0; c < NCH; c++) begin
                out_q[c]  <= OUT_RST;
                edge_q[c] <= '0;
                mask_q[c] <= '0;
            end
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= 2'd0;
            irq_q   <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                rv_q[i]   <= 1'b0;
                rdat_q[i] <= '0;
                rrsp_q[i] <= 2'b00;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                out_q[c]  <= out_d[c];
                edge_q[c] <= edge_d[c];
                mask_q[c] <= mask_d[c];
            end
            sync1_q <= pio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= arm_d;
            irq_q   <= irq_d;
            rv_q[0]   <= rd_acc;
            rdat_q[0] <= rd_acc ? rd_data : 32'd0;
            rrsp_q[0] <= rd_acc ? rd_rsp : 2'b00;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i]   <= rv_q[i-1];
                rdat_q[i] <= rdat_q[i-1];
                rrsp_q[i] <= rrsp_q[i-1];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign pio_out[c*WIDTH +: WIDTH] = out_q[c];
    end

    assign avs_waitrequest   = 1'b0;
    assign avs_readdata      = rdat_q[RD_LAT-1];
    assign avs_readdatavalid = rv_q[RD_LAT-1];
    assign avs_response      = rrsp_q[RD_LAT-1];
    assign irq               = irq_q;
endmodule

// File: tb/tb_avl_pio_multi.sv
// Self-checking bench for avl_pio_multi against a register-level reference model.
module tb_avl_pio_multi;
    localparam int NCH = 5;
    localparam int WIDTH = 16;
    localparam int EDGE_MODE = 0;
    localparam int RD_LAT = 2;
    localparam logic [WIDTH-1:0] OUT_RST = 16'hA5A5;
    localparam int ADDR_W = $clog2(NCH) + 3;

    logic clk, rst;
    logic [ADDR_W-1:0] avs_address;
    logic avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0] avs_byteenable;
    logic avs_waitrequest;
    logic [31:0] avs_readdata;
    logic avs_readdatavalid;
    logic [1:0] avs_response;
    logic [NCH*WIDTH-1:0] pio_in, pio_out;
    logic irq;

    int n_checks = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] m_out [NCH];
    logic [WIDTH-1:0] m_edge [NCH];
    logic [WIDTH-1:0] m_mask [NCH];
    logic [NCH*WIDTH-1:0] m_pin;
    logic [31:0] exp_q [$];

    avl_pio_multi #(.NCH(NCH), .WIDTH(WIDTH), .EDGE_MODE(EDGE_MODE), .RD_LAT(RD_LAT),
                    .OUT_RST(OUT_RST)) dut (
        .clk_clk(clk), .reset_reset(rst), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_response(avs_response),
        .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_out[c] = OUT_RST; m_edge[c] = '0; m_mask[c] = '0;
        end
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                        input logic [3:0] be);
        int ch = int'(a) / 8;
        int rg = int'(a) % 8;
        logic [31:0] lanes = 0;
        logic [WIDTH-1:0] m, v;
        if (ch >= NCH || rg > 5) return;
        for (int b = 0; b < 4; b++) if (be[b]) lanes = lanes | (32'hFF << (8 * b));
        m = lanes[WIDTH-1:0];
        v = wd[WIDTH-1:0] & m;
        case (rg)
            1: m_out[ch] = (m_out[ch] & ~m) | v;
            2: m_out[ch] = m_out[ch] | v;
            3: m_out[ch] = m_out[ch] & ~v;
            4: m_edge[ch] = m_edge[ch] & ~v;
            5: m_mask[ch] = (m_mask[ch] & ~m) | v;
            default: ;
        endcase
    endfunction

    function automatic void model_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                                       output logic [1:0] r);
        int ch = int'(a) / 8;
        int rg = int'(a) % 8;
        d = 0; r = 2'b00;
        if (ch >= NCH || rg > 5) begin r = 2'b10; return; end
        case (rg)
            0: d = 32'(m_pin[ch*WIDTH +: WIDTH]);
            1, 2, 3: d = 32'(m_out[ch]);
            4: d = 32'(m_edge[ch]);
            default: d = 32'(m_mask[ch]);
        endcase
    endfunction

    function automatic logic model_irq();
        logic any = 1'b0;
        for (int c = 0; c < NCH; c++) if ((m_edge[c] & m_mask[c]) != 0) any = 1'b1;
        return any;
    endfunction

    function automatic logic [NCH*WIDTH-1:0] model_pio();
        logic [NCH*WIDTH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*WIDTH +: WIDTH] = m_out[c];
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic bus_idle();
        avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0; avs_byteenable = '0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        avs_address = a; avs_writedata = wd; avs_byteenable = be; avs_write = 1;
        @(negedge clk);
        avs_write = 0;
        model_write(a, wd, be);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int lat);
        @(negedge clk);
        avs_address = a; avs_read = 1;
        @(negedge clk);
        avs_read = 0; lat = 1;
        while (!avs_readdatavalid && lat < 10) begin @(negedge clk); lat++; end
        d = avs_readdata; r = avs_response;
        if (!avs_readdatavalid) lat = -1;
    endtask

    // Drive new pin values and let them pass the synchroniser before folding edges into the model.
    task automatic set_pins(input logic [NCH*WIDTH-1:0] np);
        logic [NCH*WIDTH-1:0] ev;
        @(negedge clk);
        pio_in = np;
        repeat (5) @(negedge clk);
        case (EDGE_MODE)
            0: ev = np & ~m_pin;
            1: ev = ~np & m_pin;
            default: ev = np ^ m_pin;
        endcase
        for (int c = 0; c < NCH; c++) m_edge[c] = m_edge[c] | ev[c*WIDTH +: WIDTH];
        m_pin = np;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int lat;
        bus_idle();
        pio_in = '0; pio_in[3] = 1'b1;
        rst = 0;
        #2 rst = 1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pio_out !== {NCH{OUT_RST}}) begin
            n_fail++; $display("FAIL reset_pio_out got=%h exp=%h", pio_out, {NCH{OUT_RST}});
        end
        n_checks++;
        if ({irq, avs_readdatavalid, avs_response, avs_waitrequest} !== 5'b0 || avs_readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs irq=%b rdv=%b rsp=%b wr=%b rd=%h exp all zero",
                               irq, avs_readdatavalid, avs_response, avs_waitrequest, avs_readdata);
        end
        rst = 0;
        model_reset();
        m_pin = pio_in;
        repeat (6) @(negedge clk);
        set_pins('0);
        do_read(ADDR_W'(4), d, r, lat);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL held_pin_edge got=%h exp=0", d); end
        do_read(ADDR_W'(2*8+1), d, r, lat);
        n_checks++;
        if (lat !== RD_LAT) begin n_fail++; $display("FAIL read_latency got=%0d exp=%0d", lat, RD_LAT); end
        n_checks++;
        if (d !== 32'h0000A5A5 || r !== 2'b00) begin
            n_fail++; $display("FAIL reset_read_out got=%h/%b exp=0000a5a5/00", d, r);
        end
        @(negedge clk);
        n_checks++;
        if (avs_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rdv_pulse got=1 exp=0"); end
    endtask

    task automatic test_out_setclr();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(ADDR_W'(9), 32'h0000_00F0, 4'hF);
        n_checks++;
        if (pio_out[31:16] !== 16'h00F0) begin n_fail++; $display("FAIL out_write got=%h exp=00f0", pio_out[31:16]); end
        wr(ADDR_W'(10), 32'hFFFF_0F00, 4'hF);
        n_checks++;
        if (pio_out[31:16] !== 16'h0FF0) begin n_fail++; $display("FAIL out_set got=%h exp=0ff0", pio_out[31:16]); end
        wr(ADDR_W'(11), 32'h0000_0030, 4'hF);
        n_checks++;
        if (pio_out[31:16] !== 16'h0FC0) begin n_fail++; $display("FAIL out_clr got=%h exp=0fc0", pio_out[31:16]); end
        wr(ADDR_W'(9), 32'h0000_1234, 4'b0001);
        n_checks++;
        if (pio_out[31:16] !== 16'h0F34) begin n_fail++; $display("FAIL out_byteen got=%h exp=0f34", pio_out[31:16]); end
        do_read(ADDR_W'(10), d, r, lat);
        n_checks++;
        if (d !== 32'h0000_0F34) begin n_fail++; $display("FAIL set_readback got=%h exp=00000f34", d); end
        n_checks++;
        if (pio_out !== model_pio()) begin n_fail++; $display("FAIL other_channels got=%h exp=%h", pio_out, model_pio()); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d; logic [1:0] r; int lat;
        logic [NCH*WIDTH-1:0] p;
        p = m_pin; p[3] = 1'b1;
        set_pins(p);
        p[3] = 1'b0;
        set_pins(p);
        do_read(ADDR_W'(4), d, r, lat);
        n_checks++;
        if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL edge_rise got=%h exp=00000008", d); end
        wr(ADDR_W'(5), 32'h0000_0008, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq); end
        wr(ADDR_W'(4), 32'h0000_0008, 4'hF);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got=%b exp=1", irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
        do_read(ADDR_W'(4), d, r, lat);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL edge_w1c got=%h exp=0", d); end
    endtask

    // Pin rises two cycles before the W1C lands, so detection and clear hit the same edge.
    task automatic test_edge_w1c_same();
        logic [31:0] d; logic [1:0] r; int lat;
        wr(ADDR_W'(3*8+5), 32'h0000_0001, 4'hF);
        @(negedge clk);
        pio_in[3*WIDTH] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        avs_address = ADDR_W'(3*8+4); avs_writedata = 32'h1; avs_byteenable = 4'hF; avs_write = 1;
        @(negedge clk);
        avs_write = 0;
        m_pin[3*WIDTH] = 1'b1;
        m_edge[3][0] = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL same_cycle_irq got=%b exp=1", irq); end
        do_read(ADDR_W'(3*8+4), d, r, lat);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL same_cycle_edge got=%h exp=00000001", d); end
        wr(ADDR_W'(3*8+4), 32'h1, 4'hF);
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; int lat;
        logic [ADDR_W-1:0] bad [4];
        bad[0] = ADDR_W'(5*8+1); bad[1] = ADDR_W'(7); bad[2] = ADDR_W'(7*8); bad[3] = ADDR_W'(2*8+6);
        for (int i = 0; i < 4; i++) begin
            do_read(bad[i], d, r, lat);
            n_checks++;
            if (d !== 32'd0 || r !== 2'b10 || lat !== RD_LAT) begin
                n_fail++; $display("FAIL err_read addr=%0d got=%h/%b/%0d exp=0/10/%0d", bad[i], d, r, lat, RD_LAT);
            end
            wr(bad[i], $urandom, 4'hF);
        end
        wr(ADDR_W'(1*8), 32'hFFFF, 4'hF);
        n_checks++;
        if (pio_out !== model_pio()) begin n_fail++; $display("FAIL err_write_out got=%h exp=%h", pio_out, model_pio()); end
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] e; logic [1:0] er;
            model_read(ADDR_W'(c*8+5), e, er);
            do_read(ADDR_W'(c*8+5), d, r, lat);
            n_checks++;
            if (d !== e || r !== er) begin n_fail++; $display("FAIL err_write_mask ch=%0d got=%h exp=%h", c, d, e); end
        end
    endtask

    task automatic test_rw_collide();
        int seen = 0;
        @(negedge clk);
        avs_address = ADDR_W'(4*8+1); avs_writedata = 32'h1357; avs_byteenable = 4'hF;
        avs_write = 1; avs_read = 1;
        @(negedge clk);
        avs_write = 0; avs_read = 0;
        model_write(ADDR_W'(4*8+1), 32'h1357, 4'hF);
        for (int i = 0; i < RD_LAT + 3; i++) begin
            if (avs_readdatavalid) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL collide_rdv got=%0d exp=0", seen); end
        n_checks++;
        if (pio_out[4*WIDTH +: WIDTH] !== 16'h1357) begin
            n_fail++; $display("FAIL collide_write got=%h exp=1357", pio_out[4*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a [4];
        logic [31:0] e; logic [1:0] er;
        int got = 0;
        a[0] = ADDR_W'(16); a[1] = ADDR_W'(17); a[2] = ADDR_W'(20); a[3] = ADDR_W'(21);
        wr(ADDR_W'(21), 32'h0000_5A0F, 4'hF);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin model_read(a[i], e, er); exp_q.push_back(e); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (avs_readdatavalid) begin
                n_checks++;
                if (n !== RD_LAT + got || exp_q.size() == 0 || avs_readdata !== exp_q[0]) begin
                    n_fail++; $display("FAIL b2b_data n=%0d got=%h exp=%h at n=%0d", n, avs_readdata,
                                       (exp_q.size() != 0) ? exp_q[0] : 32'hX, RD_LAT + got);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            avs_read = (n < 4);
            avs_address = (n < 4) ? a[n] : '0;
        end
        n_checks++;
        if (got !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", got); end
    endtask

    task automatic test_random();
        logic [31:0] d, e; logic [1:0] r, er; int lat;
        logic [ADDR_W-1:0] a;
        logic [NCH*WIDTH-1:0] np;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < NCH; c++) np[c*WIDTH +: WIDTH] = WIDTH'($urandom);
                set_pins(np);
            end
            wr(ADDR_W'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
            a = ADDR_W'($urandom_range(0, 63));
            model_read(a, e, er);
            do_read(a, d, r, lat);
            n_checks++;
            if (d !== e || r !== er || lat !== RD_LAT) begin
                n_fail++; $display("FAIL rand_read it=%0d addr=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                                   it, a, d, r, lat, e, er, RD_LAT);
            end
            n_checks++;
            if (irq !== model_irq() || pio_out !== model_pio()) begin
                n_fail++; $display("FAIL rand_state it=%0d irq=%b exp=%b pio=%h exp=%h",
                                   it, irq, model_irq(), pio_out, model_pio());
            end
        end
    endtask

    task automatic test_reset_midread();
        int pre = 0, post = 0;
        int exp_pre = (RD_LAT == 1) ? 2 : 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (avs_readdatavalid) begin if (n <= 2) pre++; else post++; end
            if (n == 2) rst = 1;
            if (n == 5) rst = 0;
            avs_read = (n < 4 && n != 2 && n != 3) || (n == 2 && 1'b0);
            avs_address = ADDR_W'(2*8+1);
        end
        avs_read = 0;
        model_reset();
        n_checks++;
        if (pre !== exp_pre) begin n_fail++; $display("FAIL midreset_pre got=%0d exp=%0d", pre, exp_pre); end
        n_checks++;
        if (post !== 0) begin n_fail++; $display("FAIL midreset_post got=%0d exp=0", post); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (pio_out !== model_pio() || irq !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state pio=%h exp=%h irq=%b", pio_out, model_pio(), irq);
        end
    endtask

    initial begin
        test_reset();
        test_out_setclr();
        test_edge_irq();
        test_edge_w1c_same();
        test_errors();
        test_rw_collide();
        test_back_to_back();
        test_random();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
